robo_sequenciador: RTL

- Controller that sequences the Robo wall-follower against a 20x20 obstacle map held in an external synchronous ROM.
- Loads the start configuration from map row 0 and derives head/left sensors from the map for the current pose.
- Steps the robot one move at a time, applies its avancar/girar decision to the tracked pose, and counts moves.
- Stops on completion, or on an anomaly: pose off the map or inside an obstacle.

---
 rtl/robo_sequenciador.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/robo_sequenciador.sv
// Robo wall-follower sequencer: loads the start pose from map row 0,
// reads head/left sensor cells from the map ROM and steps the robot.
module robo_sequenciador #(
   parameter int MAP_DIM = 20,
   parameter int MOV_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   output logic [4:0]         mem_addr,
   input  logic [MAP_DIM-1:0] mem_data,
   output logic               head,
   output logic               left,
   output logic               passo,
   input  logic               avancar,
   input  logic               girar,
   output logic [4:0]         linha,
   output logic [4:0]         coluna,
   output logic [1:0]         orientacao,
   output logic [MOV_W-1:0]   movimentos,
   output logic               ocupado,
   output logic               concluido,
   output logic               erro
);

   typedef enum logic [3:0] {
      OCIOSO, CFG, VERIF, VERIF_R, LE_H,
      LE_L, PASSO, AMOSTRA, FIM, ERRO
   } st_t;

   localparam logic [1:0] OR_N = 2'b00;
   localparam logic [1:0] OR_S = 2'b01;
   localparam logic [1:0] OR_L = 2'b10;
   localparam logic [1:0] OR_O = 2'b11;
   localparam logic [4:0] DIM  = 5'(MAP_DIM);

   st_t              st_q, st_d;
   logic [4:0]       lin_q, lin_d, col_q, col_d;
   logic [1:0]       ori_q, ori_d;
   logic [MOV_W-1:0] tot_q, tot_d, mov_q, mov_d;
   logic             htmp_q, htmp_d;
   logic             head_q, head_d, left_q, left_d;
   logic             erro_q, erro_d;

   logic [4:0]       hd_row, hd_col, lf_row, lf_col;
   logic             hd_frc, lf_frc;

   function automatic logic cell_bit(
      input logic [MAP_DIM-1:0] row,
      input logic [4:0]         col
   );
      logic b;
      b = 1'b0;
      for (int i = 1; i <= MAP_DIM; i++)
         if (col == 5'(i)) b = row[MAP_DIM-i];
      return b;
   endfunction

   // Forced edge cells still read row linha; the data is ignored.
   always_comb begin
      hd_row = lin_q;
      hd_col = col_q;
      hd_frc = 1'b0;
      lf_row = lin_q;
      lf_col = col_q;
      lf_frc = 1'b0;
      unique case (ori_q)
         OR_N: begin
            hd_frc = (lin_q == 5'd1);
            if (!hd_frc) hd_row = lin_q - 5'd1;
            lf_frc = (col_q == 5'd1);
            lf_col = col_q - 5'd1;
         end
         OR_S: begin
            hd_frc = (lin_q == DIM);
            if (!hd_frc) hd_row = lin_q + 5'd1;
            lf_frc = (col_q == DIM);
            lf_col = col_q + 5'd1;
         end
         OR_L: begin
            hd_frc = (col_q == DIM);
            hd_col = col_q + 5'd1;
            lf_frc = (lin_q == 5'd1);
            if (!lf_frc) lf_row = lin_q - 5'd1;
         end
         default: begin
            hd_frc = (col_q == 5'd1);
            hd_col = col_q - 5'd1;
            lf_frc = (lin_q == DIM);
            if (!lf_frc) lf_row = lin_q + 5'd1;
         end
      endcase
   end

   always_comb begin
      st_d     = st_q;
      lin_d    = lin_q;
      col_d    = col_q;
      ori_d    = ori_q;
      tot_d    = tot_q;
      mov_d    = mov_q;
      htmp_d   = htmp_q;
      head_d   = head_q;
      left_d   = left_q;
      erro_d   = erro_q;
      mem_addr = 5'd0;
      unique case (st_q)
         OCIOSO: if (iniciar) begin
            erro_d = 1'b0;
            st_d   = CFG;
         end
         CFG: begin
            lin_d = mem_data[19:15];
            col_d = mem_data[14:10];
            ori_d = mem_data[9:8];
            tot_d = MOV_W'(mem_data[7:0]);
            mov_d = '0;
            st_d  = VERIF;
         end
         VERIF: begin
            if (lin_q == 5'd0 || lin_q > DIM ||
                col_q == 5'd0 || col_q > DIM) begin
               erro_d = 1'b1;
               st_d   = ERRO;
            end else begin
               mem_addr = lin_q;
               st_d     = VERIF_R;
            end
         end
         VERIF_R: begin
            if (cell_bit(mem_data, col_q)) begin
               erro_d = 1'b1;
               st_d   = ERRO;
            end else if (mov_q == tot_q) begin
               st_d = FIM;
            end else begin
               mem_addr = hd_row;
               st_d     = LE_H;
            end
         end
         LE_H: begin
            htmp_d   = hd_frc | cell_bit(mem_data, hd_col);
            mem_addr = lf_row;
            st_d     = LE_L;
         end
         LE_L: begin
            head_d = htmp_q;
            left_d = lf_frc | cell_bit(mem_data, lf_col);
            st_d   = PASSO;
         end
         PASSO: st_d = AMOSTRA;
         AMOSTRA: begin
            if (avancar) begin
               unique case (ori_q)
                  OR_N:    lin_d = lin_q - 5'd1;
                  OR_S:    lin_d = lin_q + 5'd1;
                  OR_L:    col_d = col_q + 5'd1;
                  default: col_d = col_q - 5'd1;
               endcase
            end else if (girar) begin
               unique case (ori_q)
                  OR_N:    ori_d = OR_O;
                  OR_O:    ori_d = OR_S;
                  OR_S:    ori_d = OR_L;
                  default: ori_d = OR_N;
               endcase
            end
            mov_d = mov_q + 1'b1;
            st_d  = VERIF;
         end
         FIM:     st_d = OCIOSO;
         ERRO:    st_d = OCIOSO;
         default: st_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q   <= OCIOSO;
         lin_q  <= '0;
         col_q  <= '0;
         ori_q  <= '0;
         tot_q  <= '0;
         mov_q  <= '0;
         htmp_q <= 1'b0;
         head_q <= 1'b0;
         left_q <= 1'b0;
         erro_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         lin_q  <= lin_d;
         col_q  <= col_d;
         ori_q  <= ori_d;
         tot_q  <= tot_d;
         mov_q  <= mov_d;
         htmp_q <= htmp_d;
         head_q <= head_d;
         left_q <= left_d;
         erro_q <= erro_d;
      end
   end

   assign head       = head_q;
   assign left       = left_q;
   assign linha      = lin_q;
   assign coluna     = col_q;
   assign orientacao = ori_q;
   assign movimentos = mov_q;
   assign erro       = erro_q;
   assign passo      = (st_q == PASSO);
   assign concluido  = (st_q == FIM) || (st_q == ERRO);
   assign ocupado    = (st_q != OCIOSO) && !concluido;

endmodule
